wide_add_sequencer: RTL and testbench

Multi-cycle wide adder/subtractor controller that time-shares one 16-bit `carry_select_adder` across `WORDS` 16-bit slices. It processes one slice per clock, least-significant first, and chains the carry through a register. The block sits between a requester with valid/ready operand handshake and a consumer with valid/ready result handshake. Its purpose is to provide 16·WORDS-bit arithmetic without replicating the adder datapath.

---
 rtl/wide_add_sequencer_pkg.sv | 20 ++
 rtl/wide_add_sequencer_carry_select_adder.sv | 37 +++
 rtl/wide_add_sequencer.sv | 133 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the wide add/subtract sequencer.
// Holds the slice width, the FSM state encoding and the helper that sizes
// the slice index register.
package wide_add_sequencer_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // max(1, $clog2(words)): a single-slice build still needs a 1-bit index.
  function automatic int idx_width(input int words);
    if (words <= 2) return 1;
    return $clog2(words);
  endfunction

endpackage

// File: rtl/wide_add_sequencer_carry_select_adder.sv
// carry_select_adder: WIDTH-bit adder built from BLOCK-bit carry-select
// blocks. Every block precomputes its result for carry-in 0 and 1 and the
// incoming carry only drives a mux, so the carry path is one mux per block.
// Ports:
//   a_i, b_i : addends
//   c_i      : carry in
//   sum_o    : WIDTH-bit sum
//   c_o      : carry out of the MSB
module carry_select_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);

  localparam int NB = WIDTH / BLOCK;

  logic [NB:0] carry;

  assign carry[0] = c_i;
  assign c_o      = carry[NB];

  for (genvar gi = 0; gi < NB; gi++) begin : g_blk
    logic [BLOCK:0] res0;
    logic [BLOCK:0] res1;

    assign res0 = {1'b0, a_i[gi*BLOCK +: BLOCK]} + {1'b0, b_i[gi*BLOCK +: BLOCK]};
    assign res1 = {1'b0, a_i[gi*BLOCK +: BLOCK]} + {1'b0, b_i[gi*BLOCK +: BLOCK]}
                + {{BLOCK{1'b0}}, 1'b1};
    assign {carry[gi+1], sum_o[gi*BLOCK +: BLOCK]} = carry[gi] ? res1 : res0;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: 16*WORDS-bit adder/subtractor that reuses a single
// 16-bit carry_select_adder, one slice per clock, LSB slice first, with the
// inter-slice carry held in a register.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid / in_ready         : operand handshake (a, b, sub, c_in)
//   out_valid / out_ready       : result handshake (sum, c_out, overflow)
//   sub                         : 1 = a - b (c_in ignored), 0 = a + b + c_in
//   c_out                       : carry out of MSB (for sub, 1 = no borrow)
//   overflow                    : two's-complement signed overflow
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  input  logic                    sub,
  input  logic                    c_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SLICE_W*WORDS-1:0] sum,
  output logic                    c_out,
  output logic                    overflow
);

  localparam int W  = SLICE_W * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;       // already inverted for subtraction
  logic            a_msb_q, a_msb_d;
  logic            b_msb_q, b_msb_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            ovf_q, ovf_d;

  logic [SLICE_W-1:0] a_slice, b_slice, add_sum;
  logic               add_co;

  assign a_slice = a_q[SLICE_W*int'(idx_q) +: SLICE_W];
  assign b_slice = b_q[SLICE_W*int'(idx_q) +: SLICE_W];

  carry_select_adder #(
    .WIDTH (SLICE_W),
    .BLOCK (4)
  ) u_adder (
    .a_i   (a_slice),
    .b_i   (b_slice),
    .c_i   (carry_q),
    .sum_o (add_sum),
    .c_o   (add_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          a_msb_d = a[W-1];
          b_msb_d = sub ? ~b[W-1] : b[W-1];
          // Subtraction is a + ~b + 1, so the "+1" enters as carry-in.
          carry_d = sub | c_in;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[SLICE_W*int'(idx_q) +: SLICE_W] = add_sum;
        carry_d = add_co;
        if (idx_q == LAST_IDX) begin
          // Same-sign operands producing an opposite-sign result.
          ovf_d   = (a_msb_q == b_msb_q) && (add_sum[SLICE_W-1] != a_msb_q);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign c_out     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (WORDS = 4).
// A monitor on the falling edge compares handshake flags every cycle and the
// result whenever a result is due, against an arithmetic reference model.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  always #5 clk = ~clk;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: cycles_left = -1 idle, >0 computing, 0 result held.
  int           cycles_left = -1;
  logic         started     = 1'b0;
  logic         after_rst   = 1'b0;
  logic [W-1:0] exp_sum;
  logic         exp_c;
  logic         exp_v;
  logic [W-1:0] obs_sum;
  logic         obs_c;
  logic         obs_v;
  int           n_done = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  // Reference arithmetic: returns {overflow, carry, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s, input logic ci);
    logic [W:0]          u;
    logic signed [W+1:0] sx, sy, r;
    logic                v;
    sx = $signed({{2{x[W-1]}}, x});
    sy = $signed({{2{y[W-1]}}, y});
    if (s) begin
      u    = {1'b0, x - y};
      u[W] = (x >= y);              // no borrow
      r    = sx - sy;
    end else begin
      u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r = sx + sy + $signed({{(W+1){1'b0}}, ci});
    end
    // Result fits a W-bit signed value iff the top three bits agree.
    v = (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
    return {v, u};
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, cycles_left == -1});
      chk("out_valid", {63'd0, out_valid}, {63'd0, cycles_left == 0});
      if (cycles_left == 0) begin
        chk("sum", sum, exp_sum);
        chk("c_out", {63'd0, c_out}, {63'd0, exp_c});
        chk("overflow", {63'd0, overflow}, {63'd0, exp_v});
      end
      if (after_rst) begin
        chk("rst_sum", sum, '0);
        chk("rst_c_out", {63'd0, c_out}, '0);
        chk("rst_overflow", {63'd0, overflow}, '0);
      end
    end
    // Predict the effect of the coming rising edge.
    if (rst) begin
      cycles_left = -1;
      after_rst   = 1'b1;
      started     = 1'b1;
    end else if (started) begin
      after_rst = 1'b0;
      if (cycles_left == -1) begin
        if (in_valid) begin
          {exp_v, exp_c, exp_sum} = ref_op(a, b, sub, c_in);
          cycles_left = WORDS;
        end
      end else if (cycles_left > 0) begin
        cycles_left--;
      end else if (out_ready) begin
        obs_sum     = sum;
        obs_c       = c_out;
        obs_v       = overflow;
        n_done++;
        cycles_left = -1;
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept_wait", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic s, input logic ci, input int hold);
    int t;
    wait_ready();
    a = x; b = y; sub = s; c_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom); c_in = 1'($urandom);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("result_wait", {63'd0, out_valid}, 64'd1);
    repeat (hold) begin
      in_valid = 1'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return {1'b0, {(W-1){1'b1}}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return W'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int done_before;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Carry ripple across all slices.
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    chk("ripple_sum", obs_sum, 64'd0);
    chk("ripple_c", {63'd0, obs_c}, 64'd1);
    chk("ripple_v", {63'd0, obs_v}, 64'd0);
    op(64'd0, 64'd0, 1'b0, 1'b1, 0);
    chk("cin_sum", obs_sum, 64'd1);

    // Subtraction.
    op(64'd5, 64'd7, 1'b1, 1'b1, 1);
    chk("sub57_sum", obs_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub57_c", {63'd0, obs_c}, 64'd0);
    chk("sub57_v", {63'd0, obs_v}, 64'd0);
    op(64'd7, 64'd5, 1'b1, 1'b0, 0);
    chk("sub75_sum", obs_sum, 64'd2);
    chk("sub75_c", {63'd0, obs_c}, 64'd1);

    // Signed overflow.
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    chk("ovf_add_sum", obs_sum, 64'h8000_0000_0000_0000);
    chk("ovf_add_v", {63'd0, obs_v}, 64'd1);
    chk("ovf_add_c", {63'd0, obs_c}, 64'd0);
    op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 0);
    chk("ovf_sub_v", {63'd0, obs_v}, 64'd1);

    // Backpressure: 10 held cycles with input noise, then a follow-up op.
    op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 10);
    chk("bp_sum", obs_sum, 64'h1234_5678_9ABC_DF00);
    op(64'd100, 64'd1, 1'b1, 1'b0, 0);
    chk("bp_next_sum", obs_sum, 64'd99);

    // Reset on the second computing cycle discards the operation.
    done_before = n_done;
    wait_ready();
    a = 64'hDEAD_BEEF_0000_FFFF; b = 64'd1; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_result", 64'(n_done), 64'(done_before));
    op(64'h1234, 64'h0001, 1'b0, 1'b0, 0);
    chk("after_abort_sum", obs_sum, 64'h1235);

    // Reset while a result is being held.
    wait_ready();
    a = 64'd3; b = 64'd4; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      op(pick(), pick(), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
